// File: rtl/ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// ram_access_ctrl
//
// Purpose:
//   Arbitrates and sequences the shared main-memory RAM between two requesters:
//   the window-fetch path (one 5x5 window read per transaction) and the
//   result-writeback path (one 16-bit word write per transaction). Read and
//   write contend round-robin. Every transaction is followed by an enable-low
//   release phase that lasts until the RAM drops its finish flag. The fetched
//   window is registered locally so it stays valid after the RAM is released.
//
// Configuration:
//   RAM_TIMEOUT_EN  - when defined, adds a per-transaction watchdog
//                     (parameter TIMEOUT_CYCLES, default 64). A transaction
//                     that sees no ram_finish within the limit is closed with
//                     an err pulse and its done pulse. When undefined the
//                     controller waits indefinitely and err is constant 0.
//
// Ports:
//   clk             in   system clock, all logic on the rising edge
//   rst             in   synchronous active-high reset
//   rd_req          in   window-read request (level, held until rd_done)
//   rd_addr         in   window top-left address
//   rd_offset       in   window row stride
//   rd_done         out  one-cycle pulse, rd_window valid
//   rd_window       out  captured 5x5 window, held until the next read completes
//   wr_req          in   write request (level, held until wr_done)
//   wr_addr         in   write address
//   wr_data         in   write data
//   wr_done         out  one-cycle pulse, write committed
//   ram_enable      out  RAM enable
//   ram_write       out  RAM write select
//   ram_address     out  RAM address
//   ram_offset      out  RAM row stride
//   ram_input_data  out  RAM write data
//   ram_output_data in   RAM 5x5 read data
//   ram_finish      in   RAM finish flag
//   busy            out  high whenever the controller is not idle
//   err             out  one-cycle watchdog timeout pulse
// -----------------------------------------------------------------------------
module ram_access_ctrl
`ifdef RAM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd64
)
`endif
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_req,
    input  logic [15:0]                 rd_addr,
    input  logic [15:0]                 rd_offset,
    output logic                        rd_done,
    output logic [0:4][0:4][15:0]       rd_window,
    input  logic                        wr_req,
    input  logic [15:0]                 wr_addr,
    input  logic [15:0]                 wr_data,
    output logic                        wr_done,
    output logic                        ram_enable,
    output logic                        ram_write,
    output logic [15:0]                 ram_address,
    output logic [15:0]                 ram_offset,
    output logic [15:0]                 ram_input_data,
    input  logic [0:4][0:4][15:0]       ram_output_data,
    input  logic                        ram_finish,
    output logic                        busy,
    output logic                        err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e                  state_q;
    logic                    last_grant_wr_q;   // 1: last grant went to the write side
    logic                    ram_enable_q;
    logic                    ram_write_q;
    logic [15:0]             ram_address_q;
    logic [15:0]             ram_offset_q;
    logic [15:0]             ram_input_data_q;
    logic                    rd_done_q;
    logic                    wr_done_q;
    logic                    busy_q;
    logic                    err_q;
    logic [0:4][0:4][15:0]   rd_window_q;

    logic                    grant_rd_d;
    logic                    grant_wr_d;
    logic                    tmo_hit_d;

    // Round-robin arbitration: on a tie the side that did not win last time goes.
    function automatic logic pick_read(input logic rd, input logic wr, input logic last_wr);
        logic res;
        if (rd && wr) begin
            res = last_wr;
        end else begin
            res = rd;
        end
        return res;
    endfunction

    // Grant decode; requests are only considered while idle.
    always_comb begin
        grant_rd_d = 1'b0;
        grant_wr_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (rd_req || wr_req) begin
                grant_rd_d = pick_read(rd_req, wr_req, last_grant_wr_q);
                grant_wr_d = ~grant_rd_d;
            end else begin
                grant_rd_d = 1'b0;
                grant_wr_d = 1'b0;
            end
        end else begin
            grant_rd_d = 1'b0;
            grant_wr_d = 1'b0;
        end
    end

`ifdef RAM_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic [15:0] tmo_cnt_d;
    logic        in_wait_s;

    // Watchdog hit: the incremented count reaches the limit while the RAM is silent.
    always_comb begin
        in_wait_s = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (in_wait_s && !ram_finish) begin
            tmo_hit_d = (tmo_cnt_d == 16'(TIMEOUT_CYCLES));
        end else begin
            tmo_hit_d = 1'b0;
        end
    end

    // Watchdog counter: cleared on every grant, counts cycles spent waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= 16'd0;
        end else if (grant_rd_d || grant_wr_d) begin
            tmo_cnt_q <= 16'd0;
        end else if (in_wait_s) begin
            tmo_cnt_q <= tmo_cnt_d;
        end else begin
            tmo_cnt_q <= tmo_cnt_q;
        end
    end
`else
    assign tmo_hit_d = 1'b0;
`endif

    // Main sequencer: grant, wait for finish, release; all outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            last_grant_wr_q  <= 1'b1;
            ram_enable_q     <= 1'b0;
            ram_write_q      <= 1'b0;
            ram_address_q    <= 16'd0;
            ram_offset_q     <= 16'd0;
            ram_input_data_q <= 16'd0;
            rd_done_q        <= 1'b0;
            wr_done_q        <= 1'b0;
            busy_q           <= 1'b0;
            err_q            <= 1'b0;
            rd_window_q      <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_rd_d) begin
                        ram_address_q   <= rd_addr;
                        ram_offset_q    <= rd_offset;
                        ram_write_q     <= 1'b0;
                        ram_enable_q    <= 1'b1;
                        last_grant_wr_q <= 1'b0;
                        busy_q          <= 1'b1;
                        state_q         <= S_RD_WAIT;
                    end else if (grant_wr_d) begin
                        ram_address_q    <= wr_addr;
                        ram_input_data_q <= wr_data;
                        ram_write_q      <= 1'b1;
                        ram_enable_q     <= 1'b1;
                        last_grant_wr_q  <= 1'b1;
                        busy_q           <= 1'b1;
                        state_q          <= S_WR_WAIT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RD_WAIT: begin
                    if (ram_finish) begin
                        rd_window_q  <= ram_output_data;
                        rd_done_q    <= 1'b1;
                        ram_enable_q <= 1'b0;
                        state_q      <= S_RELEASE;
                    end else if (tmo_hit_d) begin
                        // Window is left untouched: the RAM never delivered data.
                        err_q        <= 1'b1;
                        rd_done_q    <= 1'b1;
                        ram_enable_q <= 1'b0;
                        ram_write_q  <= 1'b0;
                        state_q      <= S_RELEASE;
                    end else begin
                        state_q <= S_RD_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (ram_finish) begin
                        wr_done_q    <= 1'b1;
                        ram_enable_q <= 1'b0;
                        ram_write_q  <= 1'b0;
                        state_q      <= S_RELEASE;
                    end else if (tmo_hit_d) begin
                        err_q        <= 1'b1;
                        wr_done_q    <= 1'b1;
                        ram_enable_q <= 1'b0;
                        ram_write_q  <= 1'b0;
                        state_q      <= S_RELEASE;
                    end else begin
                        state_q <= S_WR_WAIT;
                    end
                end
                S_RELEASE: begin
                    // Enable stays low until the RAM has cleared its finish flag.
                    if (!ram_finish) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RELEASE;
                    end
                end
                default: begin
                    ram_enable_q <= 1'b0;
                    ram_write_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_done        = rd_done_q;
    assign rd_window      = rd_window_q;
    assign wr_done        = wr_done_q;
    assign ram_enable     = ram_enable_q;
    assign ram_write      = ram_write_q;
    assign ram_address    = ram_address_q;
    assign ram_offset     = ram_offset_q;
    assign ram_input_data = ram_input_data_q;
    assign busy           = busy_q;
    assign err            = err_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_access_ctrl
//
// Directed bench for ram_access_ctrl with a behavioural RAM: reads finish one
// enabled cycle after the grant, writes two; memory[i] = i unless written.
// The RAM can hold its finish flag for extra cycles after enable drops, or
// never finish (watchdog build, RAM_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_ram_access_ctrl;

    logic                      clk;
    logic                      rst;
    logic                      rd_req;
    logic [15:0]               rd_addr;
    logic [15:0]               rd_offset;
    logic                      rd_done;
    logic [0:4][0:4][15:0]     rd_window;
    logic                      wr_req;
    logic [15:0]               wr_addr;
    logic [15:0]               wr_data;
    logic                      wr_done;
    logic                      ram_enable;
    logic                      ram_write;
    logic [15:0]               ram_address;
    logic [15:0]               ram_offset;
    logic [15:0]               ram_input_data;
    logic [0:4][0:4][15:0]     ram_output_data;
    logic                      ram_finish;
    logic                      busy;
    logic                      err;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef RAM_TIMEOUT_EN
    ram_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
`else
    ram_access_ctrl dut (
`endif
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_offset(rd_offset),
        .rd_done(rd_done), .rd_window(rd_window),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .ram_enable(ram_enable), .ram_write(ram_write), .ram_address(ram_address),
        .ram_offset(ram_offset), .ram_input_data(ram_input_data),
        .ram_output_data(ram_output_data), .ram_finish(ram_finish),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [15:0] wlog_a [0:15];
    logic [15:0] wlog_d [0:15];
    int          wlog_n = 0;
    logic        fin_r;
    logic [1:0]  cnt;
    int          hold_left;
    int          extra_hold;
    bit          never_finish;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        for (int k = wlog_n - 1; k >= 0; k--) begin
            if (wlog_a[k] == a) return wlog_d[k];
        end
        return a;
    endfunction

    assign ram_finish = ram_enable ? fin_r : (hold_left != 0);

    always @(posedge clk) begin
        if (rst) begin
            fin_r     <= 1'b0;
            cnt       <= 2'd0;
            hold_left <= 0;
        end else if (ram_enable) begin
            if (fin_r) begin
                fin_r     <= 1'b0;
                cnt       <= 2'd0;
                hold_left <= extra_hold;
            end else if (!never_finish) begin
                if (int'(cnt) + 1 >= (ram_write ? 2 : 1)) begin
                    fin_r <= 1'b1;
                    if (ram_write) begin
                        if (wlog_n < 16) begin
                            wlog_a[wlog_n] <= ram_address;
                            wlog_d[wlog_n] <= ram_input_data;
                            wlog_n         <= wlog_n + 1;
                        end
                    end else begin
                        for (int r = 0; r < 5; r++)
                            for (int c = 0; c < 5; c++)
                                ram_output_data[r][c] <= mem_rd(16'(ram_address + ram_offset * 16'(r) + 16'(c)));
                    end
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end else begin
            cnt <= 2'd0;
            if (hold_left != 0) hold_left <= hold_left - 1;
        end
    end

    // ---------------- grant monitor ----------------
    bit   grants[$];
    logic en_prev;
    int   low_run;
    int   min_gap;
    bit   mon_clr;

    always @(negedge clk) begin
        if (mon_clr) begin
            grants.delete();
            en_prev <= 1'b0;
            low_run <= 0;
            min_gap <= 1000;
        end else begin
            if (ram_enable && !en_prev) begin
                grants.push_back(ram_write);
                if (grants.size() > 1 && low_run < min_gap) min_gap <= low_run;
            end
            low_run <= ram_enable ? 0 : low_run + 1;
            en_prev <= ram_enable;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int  n_done;
    bit  rd_low;
    bit  wr_low;

    initial begin
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = 16'd0; rd_offset = 16'd0; wr_addr = 16'd0; wr_data = 16'd0;
        extra_hold = 0; never_finish = 1'b0; mon_clr = 1'b1;
        tick(); tick(); tick();

        // Reset state
        check("rst_enable", ram_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_err", err, 0);
        check("rst_addr", ram_address, 0);
        check("rst_win44", rd_window[4][4], 0);
        rst = 1'b0;
        tick();

        // Read 100 / stride 28
        rd_req = 1'b1; rd_addr = 16'd100; rd_offset = 16'd28;
        tick();
        check("rd_grant_en", ram_enable, 1);
        check("rd_grant_wr", ram_write, 0);
        check("rd_grant_addr", ram_address, 100);
        check("rd_grant_off", ram_offset, 28);
        check("rd_grant_busy", busy, 1);
        tick();
        check("rd_done_c1", rd_done, 0);
        tick();
        check("rd_done_c2", rd_done, 1);
        check("rd_win00", rd_window[0][0], 100);
        check("rd_win23", rd_window[2][3], 159);
        check("rd_win44", rd_window[4][4], 216);
        check("rd_en_low", ram_enable, 0);
        check("rd_err", err, 0);
        rd_req = 1'b0;
        tick();
        check("rd_done_c3", rd_done, 0);
        check("rd_busy_c3", busy, 0);
        check("rd_win_hold", rd_window[4][4], 216);

        // Write 500 <= 1234
        wr_req = 1'b1; wr_addr = 16'd500; wr_data = 16'h1234;
        tick();
        check("wr_grant_en", ram_enable, 1);
        check("wr_grant_wr", ram_write, 1);
        check("wr_grant_addr", ram_address, 500);
        check("wr_grant_data", ram_input_data, 16'h1234);
        tick();
        check("wr_done_c1", wr_done, 0);
        tick();
        check("wr_done_c2", wr_done, 0);
        tick();
        check("wr_done_c3", wr_done, 1);
        check("wr_en_low", ram_enable, 0);
        check("wr_write_low", ram_write, 0);
        wr_req = 1'b0;
        tick();
        check("wr_done_c4", wr_done, 0);
        check("wr_busy_c4", busy, 0);

        // Read back 500
        rd_req = 1'b1; rd_addr = 16'd500; rd_offset = 16'd28;
        tick(); tick(); tick();
        check("rb_done", rd_done, 1);
        check("rb_win00", rd_window[0][0], 16'h1234);
        check("rb_win01", rd_window[0][1], 501);
        check("rb_win10", rd_window[1][0], 528);
        rd_req = 1'b0;
        tick();

        // Round-robin: both requesting from reset, four grants
        rst = 1'b1; mon_clr = 1'b1;
        rd_req = 1'b1; rd_addr = 16'd40; rd_offset = 16'd3;
        wr_req = 1'b1; wr_addr = 16'd800; wr_data = 16'd8;
        tick();
        rst = 1'b0; mon_clr = 1'b0;
        n_done = 0; rd_low = 1'b0; wr_low = 1'b0;
        for (int i = 0; i < 100 && n_done < 4; i++) begin
            tick();
            if (rd_low) begin rd_req = 1'b1; rd_low = 1'b0; end
            if (wr_low) begin wr_req = 1'b1; wr_low = 1'b0; end
            if (rd_done) begin n_done++; rd_req = 1'b0; rd_low = 1'b1; end
            if (wr_done) begin n_done++; wr_req = 1'b0; wr_low = 1'b1; end
        end
        rd_req = 1'b0; wr_req = 1'b0;
        check("rr_done_count", n_done, 4);
        tick(); tick(); tick();
        check("rr_grants", grants.size(), 4);
        if (grants.size() == 4) begin
            check("rr_g0_read", grants[0], 0);
            check("rr_g1_write", grants[1], 1);
            check("rr_g2_read", grants[2], 0);
            check("rr_g3_write", grants[3], 1);
        end
        check("rr_gap_ge1", (min_gap >= 1), 1);
        check("rr_idle", busy, 0);

        // Reset during WR_WAIT, then re-issue
        wr_req = 1'b1; wr_addr = 16'd600; wr_data = 16'hBEEF;
        tick();
        check("rw_grant", ram_enable, 1);
        tick();
        rst = 1'b1;
        tick();
        check("rw_en", ram_enable, 0);
        check("rw_busy", busy, 0);
        check("rw_wr_done", wr_done, 0);
        check("rw_win_clr", rd_window[0][0], 0);
        rst = 1'b0;
        tick();
        check("rw_regrant_en", ram_enable, 1);
        check("rw_regrant_wr", ram_write, 1);
        check("rw_regrant_addr", ram_address, 600);
        tick();
        check("rw_done_c1", wr_done, 0);
        tick();
        check("rw_done_c2", wr_done, 0);
        tick();
        check("rw_done_c3", wr_done, 1);
        wr_req = 1'b0;
        tick();
        rd_req = 1'b1; rd_addr = 16'd600; rd_offset = 16'd1;
        tick(); tick(); tick();
        check("rw_rb_done", rd_done, 1);
        check("rw_rb_win00", rd_window[0][0], 16'hBEEF);
        rd_req = 1'b0;
        tick();

        // Finish held 3 cycles after enable drops; pending read waits
        extra_hold = 3;
        wr_req = 1'b1; wr_addr = 16'd700; wr_data = 16'd7;
        tick();
        tick();
        rd_req = 1'b1; rd_addr = 16'd10; rd_offset = 16'd1;
        tick();
        tick();
        check("hold_wr_done", wr_done, 1);
        wr_req = 1'b0; extra_hold = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_busy", busy, 1);
            check("hold_en", ram_enable, 0);
        end
        tick();
        check("hold_idle_busy", busy, 0);
        check("hold_idle_en", ram_enable, 0);
        tick();
        check("hold_rd_grant", ram_enable, 1);
        check("hold_rd_wr", ram_write, 0);
        check("hold_rd_addr", ram_address, 10);
        tick(); tick();
        check("hold_rd_done", rd_done, 1);
        check("hold_win00", rd_window[0][0], 10);
        check("hold_win44", rd_window[4][4], 18);
        rd_req = 1'b0;
        tick();

`ifdef RAM_TIMEOUT_EN
        // Watchdog: RAM never finishes
        never_finish = 1'b1;
        rd_req = 1'b1; rd_addr = 16'd20; rd_offset = 16'd2;
        tick();
        check("tmo_grant", ram_enable, 1);
        for (int k = 0; k < 7; k++) tick();
        check("tmo_c7_err", err, 0);
        check("tmo_c7_done", rd_done, 0);
        tick();
        check("tmo_err", err, 1);
        check("tmo_rd_done", rd_done, 1);
        check("tmo_en_low", ram_enable, 0);
        check("tmo_win_kept", rd_window[0][0], 10);
        rd_req = 1'b0; never_finish = 1'b0;
        tick();
        check("tmo_err_clr", err, 0);
        check("tmo_idle", busy, 0);
`else
        check("no_tmo_err", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Sequences and arbitrates the shared main-memory RAM between two requesters: the window-fetch path (reads one 5x5 window) and the result-writeback path (writes single words).
- Drives the RAM enable/write/address/offset/input_data pins and waits on its finish flag.
- Registers each fetched window so it stays stable after the RAM is released.
- Enforces an enable-low release cycle between transactions, which clears the RAM finish flag.

Parameters:
- TIMEOUT_CYCLES, 64, watchdog limit in clk cycles per transaction (used only with RAM_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rd_req  input  1  window-read request; level; held with rd_addr/rd_offset stable until rd_done.
- rd_addr  input  16 (shortint)  window top-left address.
- rd_offset  input  16 (shortint)  row stride.
- rd_done  output  1  one-cycle pulse; rd_window valid.
- rd_window  output  5x5x16 (shortint [0:4][0:4])  captured window; holds until next read completes.
- wr_req  input  1  write request; level; held with wr_addr/wr_data stable until wr_done.
- wr_addr  input  16  write address.
- wr_data  input  16  write data.
- wr_done  output  1  one-cycle pulse; write committed.
- ram_enable  output  1  to RAM enable.
- ram_write  output  1  to RAM write.
- ram_address  output  16  to RAM address.
- ram_offset  output  16  to RAM offset.
- ram_input_data  output  16  to RAM input_data.
- ram_output_data  input  5x5x16  from RAM output_data.
- ram_finish  input  1  from RAM finish.
- busy  output  1  high whenever state != IDLE.
- err  output  1  one-cycle timeout pulse; tied 0 without RAM_TIMEOUT_EN.

Behaviour:
- All state registers, outputs and drive registers are registered.
- Reset values: state=IDLE; ram_enable, ram_write, rd_done, wr_done, busy, err = 0; ram_address, ram_offset, ram_input_data = 0; rd_window all 0; last_grant=WRITE, so read wins the first tie.
- FSM state IDLE:
  - Only rd_req: latch rd_addr→ram_address and rd_offset→ram_offset; set ram_write=0, ram_enable=1; go to RD_WAIT.
  - Only wr_req: latch wr_addr→ram_address and wr_data→ram_input_data; set ram_write=1, ram_enable=1; go to WR_WAIT.
  - Both: grant the side opposite last_grant; update last_grant on every grant (round-robin).
- FSM state RD_WAIT:
  - On a posedge with ram_finish=1: capture ram_output_data into rd_window; pulse rd_done; clear ram_enable; go to RELEASE.
- FSM state WR_WAIT:
  - On a posedge with ram_finish=1: pulse wr_done; clear ram_enable and ram_write; go to RELEASE.
- FSM state RELEASE:
  - ram_enable stays 0 for at least one cycle.
  - Remain in RELEASE while ram_finish=1; go to IDLE once ram_finish=0.
  - No request is accepted in RELEASE.
- Latency, measured from the IDLE posedge that samples the request, with a compliant RAM:
  - Read: rd_done high in cycle +2.
  - Write: wr_done high in cycle +3.
  - Then 1 RELEASE cycle, so the next grant is no earlier than cycle +4 (read) or +5 (write).
- ram_address, ram_offset and ram_input_data are stable for the whole enable-high window.
- Requester rules:
  - A requester must drop its req in the cycle after its done pulse.
  - A req still high when the FSM re-enters IDLE is treated as a new request.
- Address arithmetic is 16-bit; no range check is done.
- Reset asserted mid-transaction: abandon the transaction. In the cycle after reset, ram_enable=0, the FSM is in IDLE, no done pulse is issued and rd_window is cleared.
- Requests arriving during RD_WAIT, WR_WAIT or RELEASE wait; they are not lost while held.

Optional Feature:
- Macro: RAM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every grant and increments each cycle in RD_WAIT or WR_WAIT.
  - When the counter reaches TIMEOUT_CYCLES with ram_finish still 0: pulse err and the pending done in the same cycle, clear ram_enable/ram_write, go to RELEASE.
  - rd_window is not updated on a read timeout.
- Undefined: no counter; the FSM waits indefinitely for ram_finish; err is constant 0.

Test Plan:
- Read, rd_addr=100, rd_offset=28, memory[i]=i → rd_done at cycle +2; rd_window[r][c]=100+28r+c (e.g. [4][4]=216); ram_enable low the next cycle.
- Write, wr_addr=500, wr_data=16'h1234 → wr_done at cycle +3; a following read at 500 returns [0][0]=16'h1234.
- rd_req and wr_req both high from reset, each held until done, then re-raised immediately, for 4 grants → order read, write, read, write; at most one ram_enable window at a time; ≥1 enable-low cycle between grants.
- rst pulsed during WR_WAIT → next cycle ram_enable=0, busy=0, no wr_done; write then re-issued and completes normally.
- RAM model holds ram_finish high 3 cycles after enable drops → FSM stays in RELEASE 3 cycles; a pending rd_req is granted only after ram_finish=0.
- With RAM_TIMEOUT_EN and TIMEOUT_CYCLES=8, RAM model never asserts ram_finish → err and rd_done pulse together 8 cycles after grant; rd_window unchanged; FSM returns to IDLE.
